// File: rtl/decode_collate_if.sv
// Handshake bundle between the fetch/buffer side, the collation pipe and
// the decoder. The slave modport is the collation pipe itself; the master
// modport is whoever feeds words in and drains collated instructions.
interface decode_collate_if #(
   parameter int WFID_W = 6,
   parameter int PC_W   = 32
);
   logic              in_valid;
   logic              in_ready;
   logic [WFID_W-1:0] in_wfid;
   logic [31:0]       in_instr;
   logic [PC_W-1:0]   in_pc;
   logic              flush_valid;
   logic [WFID_W-1:0] flush_wfid;
   logic              out_valid;
   logic              out_ready;
   logic [WFID_W-1:0] out_wfid;
   logic [63:0]       out_instr;
   logic [PC_W-1:0]   out_pc;
   logic              out_len64;
   logic [1:0]        out_fu;
   logic              out_err;

   modport master (
      output in_valid, in_wfid, in_instr, in_pc, flush_valid, flush_wfid, out_ready,
      input  in_ready, out_valid, out_wfid, out_instr, out_pc, out_len64, out_fu, out_err
   );

   modport slave (
      input  in_valid, in_wfid, in_instr, in_pc, flush_valid, flush_wfid, out_ready,
      output in_ready, out_valid, out_wfid, out_instr, out_pc, out_len64, out_fu, out_err
   );
endinterface

// File: rtl/decode_collate_pipe.sv
// Decode-stage front end: per-wavefront collation of two-word instructions
// (VOP3 / DS / MTBUF and any 32-bit encoding carrying a literal constant)
// into one 64-bit instruction, emitted through a registered valid/ready stage.
// Optional build macro DECODE_COLLATE_PC_CHECK_EN: when defined, a second word
// whose pc is not the stored first-word pc + 4 is reported as an error instead
// of being joined.
module decode_collate_pipe #(
   parameter int NUM_WF = 40,
   parameter int WFID_W = 6,
   parameter int PC_W   = 32
) (
   input logic             clk,
   input logic             rst,
   decode_collate_if.slave bus
);

   localparam logic [WFID_W:0] NUM_WF_L = (WFID_W+1)'(NUM_WF);

   localparam logic [1:0] FU_NONE   = 2'b00;
   localparam logic [1:0] FU_VECTOR = 2'b01;
   localparam logic [1:0] FU_SCALAR = 2'b10;
   localparam logic [1:0] FU_MEMORY = 2'b11;

   // collation slots; slot contents are only meaningful while pending is set
   logic [NUM_WF-1:0] pending;
   logic [NUM_WF-1:0] pending_next;
   logic [31:0]       slot_word [NUM_WF];
   logic [PC_W-1:0]   slot_pc   [NUM_WF];
   logic [1:0]        slot_fu   [NUM_WF];

   // classification of the incoming word as a first word
   logic [1:0] cls_fu;
   logic       cls_multi;
   logic       cls_bad;

   // selected slot for the incoming wavefront
   logic            cur_pending;
   logic [31:0]     cur_word;
   logic [PC_W-1:0] cur_pc;
   logic [1:0]      cur_fu;

   logic accept;
   logic in_range;
   logic flush_hit;
   logic set_pending;
   logic clr_pending;

   // next contents of the output register
   logic              load_valid;
   logic [WFID_W-1:0] load_wfid;
   logic [63:0]       load_instr;
   logic [PC_W-1:0]   load_pc;
   logic              load_len64;
   logic [1:0]        load_fu;
   logic              load_err;

   // output register
   logic              out_valid_q;
   logic [WFID_W-1:0] out_wfid_q;
   logic [63:0]       out_instr_q;
   logic [PC_W-1:0]   out_pc_q;
   logic              out_len64_q;
   logic [1:0]        out_fu_q;
   logic              out_err_q;

   assign bus.in_ready  = !out_valid_q || bus.out_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_wfid  = out_wfid_q;
   assign bus.out_instr = out_instr_q;
   assign bus.out_pc    = out_pc_q;
   assign bus.out_len64 = out_len64_q;
   assign bus.out_fu    = out_fu_q;
   assign bus.out_err   = out_err_q;

   // Decode the encoding family of a first word and whether it needs a second word
   always_comb begin
      cls_fu    = FU_NONE;
      cls_multi = 1'b0;
      cls_bad   = 1'b0;
      if (bus.in_instr[31:23] == 9'b1_0111_1111) begin
         cls_fu = FU_SCALAR;
      end else if (bus.in_instr[31:23] == 9'b1_0111_1101) begin
         cls_fu    = FU_SCALAR;
         cls_multi = (bus.in_instr[7:0] == 8'hFF);
      end else if (bus.in_instr[31:23] == 9'b1_0111_1110) begin
         cls_fu    = FU_SCALAR;
         cls_multi = (bus.in_instr[7:0] == 8'hFF) || (bus.in_instr[15:8] == 8'hFF);
      end else if (bus.in_instr[31:28] == 4'b1011) begin
         cls_fu = FU_SCALAR;
      end else if (bus.in_instr[31:30] == 2'b10) begin
         cls_fu    = FU_SCALAR;
         cls_multi = (bus.in_instr[7:0] == 8'hFF) || (bus.in_instr[15:8] == 8'hFF);
      end else if (!bus.in_instr[31]) begin
         cls_fu    = FU_VECTOR;
         cls_multi = (bus.in_instr[8:0] == 9'h0FF);
      end else if (bus.in_instr[31:26] == 6'b110100) begin
         cls_fu    = FU_VECTOR;
         cls_multi = 1'b1;
      end else if (bus.in_instr[31:27] == 5'b11000) begin
         cls_fu = FU_MEMORY;
      end else if (bus.in_instr[31:26] == 6'b110110) begin
         cls_fu    = FU_MEMORY;
         cls_multi = 1'b1;
      end else if (bus.in_instr[31:26] == 6'b111010) begin
         cls_fu    = FU_MEMORY;
         cls_multi = 1'b1;
      end else begin
         cls_bad = 1'b1;
      end
   end

   // Pick out the collation slot addressed by the incoming wavefront id
   always_comb begin
      cur_pending = 1'b0;
      cur_word    = '0;
      cur_pc      = '0;
      cur_fu      = FU_NONE;
      for (int i = 0; i < NUM_WF; i++) begin
         if (bus.in_wfid == WFID_W'(i)) begin
            cur_pending = pending[i];
            cur_word    = slot_word[i];
            cur_pc      = slot_pc[i];
            cur_fu      = slot_fu[i];
         end
      end
   end

   // Decide what an accepted word does: drop, park as a first word, or produce output
   always_comb begin
      accept      = bus.in_valid && bus.in_ready;
      in_range    = ({1'b0, bus.in_wfid} < NUM_WF_L);
      flush_hit   = bus.flush_valid && (bus.flush_wfid == bus.in_wfid);
      set_pending = 1'b0;
      clr_pending = 1'b0;
      load_valid  = 1'b0;
      load_wfid   = '0;
      load_instr  = '0;
      load_pc     = '0;
      load_len64  = 1'b0;
      load_fu     = FU_NONE;
      load_err    = 1'b0;
      if (accept) begin
         if (!in_range) begin
            load_valid = 1'b1;
            load_wfid  = bus.in_wfid;
            load_instr = {32'b0, bus.in_instr};
            load_pc    = bus.in_pc;
            load_err   = 1'b1;
         end else if (!flush_hit) begin
            if (cur_pending) begin
               clr_pending = 1'b1;
               load_valid  = 1'b1;
               load_wfid   = bus.in_wfid;
               load_instr  = {bus.in_instr, cur_word};
               load_pc     = cur_pc;
               load_len64  = 1'b1;
               load_fu     = cur_fu;
`ifdef DECODE_COLLATE_PC_CHECK_EN
               if (bus.in_pc != cur_pc + PC_W'(4)) begin
                  load_fu  = FU_NONE;
                  load_err = 1'b1;
               end
`endif
            end else if (cls_multi) begin
               set_pending = 1'b1;
            end else begin
               load_valid = 1'b1;
               load_wfid  = bus.in_wfid;
               load_instr = {32'b0, bus.in_instr};
               load_pc    = bus.in_pc;
               load_fu    = cls_fu;
               load_err   = cls_bad;
            end
         end
      end
   end

   // Pending flags: flush clears its slot, a parked first word sets, a joined second word clears
   always_comb begin
      pending_next = pending;
      for (int i = 0; i < NUM_WF; i++) begin
         if (bus.flush_valid && (bus.flush_wfid == WFID_W'(i))) begin
            pending_next[i] = 1'b0;
         end
         if (set_pending && (bus.in_wfid == WFID_W'(i))) begin
            pending_next[i] = 1'b1;
         end
         if (clr_pending && (bus.in_wfid == WFID_W'(i))) begin
            pending_next[i] = 1'b0;
         end
      end
   end

   // Pending flag register; reset forgets every parked first word
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending <= '0;
      end else begin
         pending <= pending_next;
      end
   end

   // Slot payload storage, only qualified by pending so it needs no reset
   always_ff @(posedge clk) begin
      if (set_pending) begin
         slot_word[bus.in_wfid] <= bus.in_instr;
         slot_pc[bus.in_wfid]   <= bus.in_pc;
         slot_fu[bus.in_wfid]   <= cls_fu;
      end
   end

   // Output stage: reloads whenever it is empty or being drained, otherwise holds
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_wfid_q  <= '0;
         out_instr_q <= '0;
         out_pc_q    <= '0;
         out_len64_q <= 1'b0;
         out_fu_q    <= FU_NONE;
         out_err_q   <= 1'b0;
      end else if (bus.in_ready) begin
         out_valid_q <= load_valid;
         out_wfid_q  <= load_wfid;
         out_instr_q <= load_instr;
         out_pc_q    <= load_pc;
         out_len64_q <= load_len64;
         out_fu_q    <= load_fu;
         out_err_q   <= load_err;
      end
   end

endmodule

// File: doc/decode_collate_pipe.md
Name: decode_collate_pipe

Overview:
- Front end of the decode stage: sits between the instruction fetch/buffer and the decoder.
- Keeps a collation buffer per wavefront and joins two-word instructions into one 64-bit instruction.
  - Long formats: VOP3, DS, MTBUF.
  - Any 32-bit encoding that carries a literal constant.
- Emits each completed instruction, tagged with its wavefront, through a registered valid/ready output stage.
- Unlike a purely combinational decoder, it holds the first word itself and requests nothing from upstream.

Parameters:
- NUM_WF, 40, number of wavefront collation slots.
- WFID_W, 6, wavefront id width (must satisfy 2^WFID_W >= NUM_WF).
- PC_W, 32, program counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept a word this cycle.
- in_wfid  in  WFID_W  wavefront of the input word.
- in_instr  in  32  instruction word.
- in_pc  in  PC_W  byte address of in_instr.
- flush_valid  in  1  discard collation state of one wavefront (branch/halt).
- flush_wfid  in  WFID_W  wavefront to flush.
- out_valid  out  1  collated instruction valid.
- out_ready  in  1  downstream accepts.
- out_wfid  out  WFID_W  wavefront of the output.
- out_instr  out  64  {second word, first word}; the upper half is 0 for single-word instructions.
- out_pc  out  PC_W  pc of the first word.
- out_len64  out  1  1 = two-word instruction.
- out_fu  out  2  10 scalar, 01 vector, 11 memory, 00 invalid.
- out_err  out  1  unrecognised encoding, or a check failure.

Behaviour:
- Reset: pending[] = 0, out_valid = 0, all other outputs 0. Reset asserted mid-collation discards every stored first word.
- Accept rule:
  - in_ready = !out_valid | out_ready. This is independent of wfid and of the pending state.
  - A word is accepted when in_valid & in_ready.
- Classification of the first word, on in_instr[31:0], with priority top to bottom:
  - [31:23] = 1_0111_1111 → SOPP, scalar, no literal.
  - [31:23] = 1_0111_1101 → SOP1, scalar, literal if [7:0] = 8'hFF.
  - [31:23] = 1_0111_1110 → SOPC, scalar, literal if [7:0] or [15:8] = 8'hFF.
  - [31:28] = 1011 → SOPK, scalar, no literal.
  - [31:30] = 10 → SOP2, scalar, literal if [7:0] or [15:8] = 8'hFF.
  - [31] = 0 → VOPC/VOP1/VOP2, vector, literal if [8:0] = 9'h0FF.
  - [31:26] = 110100 → VOP3, vector, long.
  - [31:27] = 11000 → SMRD, memory, no literal.
  - [31:26] = 110110 → DS, memory, long.
  - [31:26] = 111010 → MTBUF, memory, long.
  - anything else → invalid.
- Accepted word with pending[wfid] = 0:
  - Long or literal: store word and pc in buf[wfid], set pending[wfid], record fu. No output.
  - Otherwise: next cycle out_valid = 1, out_instr = {32'b0, word}, out_len64 = 0.
  - Invalid: out_fu = 00, out_err = 1.
- Accepted word with pending[wfid] = 1:
  - The word is the second word; it is not classified.
  - Next cycle: out_instr = {word, buf}, out_pc = stored pc, out_fu = stored fu, out_len64 = 1. Clear pending.
- Latency: one cycle from acceptance of the final word to out_valid.
- Backpressure: while out_valid & !out_ready, all outputs hold stable and in_ready = 0.
- Throughput: one word per cycle when out_ready = 1. Interleaving between wavefronts is arbitrary; each slot is independent.
- Flush:
  - Clears pending[flush_wfid] at the clock edge.
  - A word accepted in the same cycle for the same wfid is consumed and dropped, with no output and no slot update.
  - Words for other wfids are unaffected.
  - A flush does not cancel an instruction already in the output register.
- in_wfid >= NUM_WF: the word is consumed and dropped; out_err is pulsed with out_fu = 00.

Optional Feature:
- Macro DECODE_COLLATE_PC_CHECK_EN.
- Defined: a second word whose in_pc ≠ stored pc + 4 is not joined. The block then:
  - emits out_err = 1, out_len64 = 1, out_fu = 00, out_instr = {word, buf};
  - clears the slot.
- Undefined: in_pc is used only on the first word; the second word's pc is ignored and no check logic is built.

Test Plan:
- Reset with out_ready = 1; SOPP word 32'hBF810000, wf 3 → one cycle later out_valid, out_instr = 64'h00000000BF810000, out_fu = 10, out_len64 = 0.
- VOP3 word 32'hD2100001 then 32'h00020501, wf 5, pc 0x100 → one output only: out_instr = 64'h00020501D2100001, out_pc = 0x100, out_len64 = 1, out_fu = 01.
- Interleave: wf1 SOP2 with src0 = FF (32'h800001FF), then wf2 SOPP, then wf1 literal 32'h12345678 → wf2 SOPP is emitted first; then wf1 is emitted with upper half 32'h12345678.
- First word of DS on wf7; flush_valid on wf7 in the same cycle as the second word → no output; a following SOPP on wf7 is emitted normally.
- Hold out_ready = 0 for 4 cycles after a valid output → outputs stable, in_ready = 0, no word lost; release → next word accepted.
- With DECODE_COLLATE_PC_CHECK_EN: MTBUF first word at pc 0x200, second word at pc 0x208 → out_err = 1, out_fu = 00, slot cleared.
